// File: rtl/row_window_scan_ctrl.sv
// Sliding 6-cell window scan over a latched board line; streams de-duplicated
// highest-empty-cell candidates over a valid/ready handshake.

module priority_encoder (
    input  logic [5:0] bits,
    output logic [2:0] idx
);
    // Highest empty (zero) position wins; 7 means the window is fully occupied.
    always_comb begin
        idx = 3'd7;
        for (int i = 0; i < 6; i++) begin
            if (!bits[i]) idx = 3'(i);
        end
    end
endmodule

module row_window_scan_ctrl #(
    parameter int ROW_LEN = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ROW_LEN-1:0] row_occ,
    output logic               cand_valid,
    input  logic               cand_ready,
    output logic [4:0]         cand_col,
    output logic [4:0]         cand_win,
    output logic               busy,
    output logic               done,
    output logic [4:0]         cand_count
);
    localparam int NWIN = ROW_LEN - 5;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t             state, state_nxt;
    logic [ROW_LEN-1:0] row_q;
    logic [4:0]         off;
    logic               last_valid;
    logic [4:0]         last_col;

    logic [5:0]         win_bits;
    logic [2:0]         enc;
    logic [4:0]         col_abs;
    logic               hit;
    logic               last_off;

    // Constant-index mux keeps every window slice in range for any legal ROW_LEN.
    always_comb begin
        win_bits = '0;
        for (int o = 0; o < NWIN; o++) begin
            if (off == 5'(o)) win_bits = row_q[o +: 6];
        end
    end

    priority_encoder u_enc (
        .bits (win_bits),
        .idx  (enc)
    );

    assign col_abs  = off + 5'(enc);
    // Highest empty column never decreases with offset, so one compare de-dups.
    assign hit      = (enc != 3'd7) && !(last_valid && (col_abs == last_col));
    assign last_off = (off == 5'(NWIN - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                if (abort)         state_nxt = IDLE;
                else if (hit)      state_nxt = EMIT;
                else if (last_off) state_nxt = DONE;
            end
            EMIT: begin
                if (abort)           state_nxt = IDLE;
                else if (cand_ready) state_nxt = last_off ? DONE : SCAN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q      <= '0;
            off        <= '0;
            cand_valid <= 1'b0;
            cand_col   <= '0;
            cand_win   <= '0;
            cand_count <= '0;
            last_valid <= 1'b0;
            last_col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_q      <= row_occ;
                        off        <= '0;
                        cand_count <= '0;
                        last_valid <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!abort) begin
                        if (hit) begin
                            cand_col   <= col_abs;
                            cand_win   <= off;
                            cand_valid <= 1'b1;
                            last_col   <= col_abs;
                            last_valid <= 1'b1;
                        end else if (!last_off) begin
                            off <= off + 5'd1;
                        end
                    end
                end
                EMIT: begin
                    // Abort drops the pending candidate without counting it.
                    if (abort) begin
                        cand_valid <= 1'b0;
                    end else if (cand_ready) begin
                        cand_valid <= 1'b0;
                        cand_count <= cand_count + 5'd1;
                        if (!last_off) off <= off + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/row_window_scan_ctrl.md
Name: row_window_scan_ctrl

Overview:
- Sequencer that sweeps a latched board line (one occupancy bit per cell) with a sliding 6-cell window.
- Feeds each window to an internally instantiated priority_encoder. Converts each hit to an absolute column and streams de-duplicated candidate empty cells to the move-generation logic over a valid/ready handshake.
- Sits between the board-state register file and the candidate-move selector; one line is processed per start.

Parameters:
- ROW_LEN, 19, cells per line; legal range 6..31.
- NWIN, ROW_LEN-5, derived local parameter: number of window offsets, 0..NWIN-1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin scan; sampled only in IDLE
- abort  input  1  synchronous cancel; return to IDLE, no done pulse
- row_occ  input  ROW_LEN  occupancy, bit c = cell c, 1 = occupied; sampled on the start edge only
- cand_valid  output  1  candidate available
- cand_ready  input  1  consumer accepts candidate when high with cand_valid
- cand_col  output  5  absolute column of the empty cell
- cand_win  output  5  window offset that produced it
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at scan completion
- cand_count  output  5  candidates emitted in the current or last scan

Behaviour:
- Reset (rst_n=0 at a clock edge), required values:
  - state=IDLE, off=0, cand_valid=0, cand_col=0, cand_win=0, busy=0, done=0, cand_count=0, last_valid=0.
  - Reset has priority over abort and start, including mid-scan and mid-handshake.
- Encoder mapping:
  - Window bit i (i=0..5) = row_q[off+i], where row_q is the latched row.
  - Encoder result e is the highest i whose bit is 0, or 7 if all six cells are occupied.
  - Absolute column = off+e, computed 5 bits wide with no overflow (max ROW_LEN-1).
- IDLE:
  - On start=1: row_q<=row_occ, off<=0, cand_count<=0, last_valid<=0, go to SCAN.
  - Otherwise hold; cand_count keeps the last result.
- SCAN, one window per cycle:
  - e=7, or (last_valid and off+e==last_col): window skipped. If off==NWIN-1, go to DONE; else off<=off+1, stay in SCAN.
  - Otherwise: cand_col<=off+e, cand_win<=off, cand_valid<=1, last_col<=off+e, last_valid<=1, go to EMIT.
- EMIT:
  - Hold cand_col and cand_win stable while cand_ready=0.
  - On cand_valid&cand_ready:
    - cand_valid<=0, cand_count<=cand_count+1.
    - If off==NWIN-1, go to DONE; else off<=off+1, go to SCAN.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - busy is still 1 in DONE and drops to 0 the following cycle.
- Latency:
  - start sampled at edge k → first SCAN cycle k+1 → earliest cand_valid after edge k+1.
  - Fully occupied line: done high in cycle k+1+NWIN.
- abort=1 (SCAN/EMIT/DONE): next state IDLE, cand_valid<=0, no done pulse, cand_count frozen.
- Simultaneous abort and cand_ready in EMIT: abort wins, and the transfer does not count.
- start while busy is ignored; row_occ changes during a scan have no effect.
- De-duplication:
  - The highest empty column is non-decreasing across offsets, so comparing against the last emitted column is sufficient.
  - Each column is emitted at most once per scan.

Test Plan:
- Empty line (row_occ=0), cand_ready=1 → 14 candidates (col,win) = (5,0),(6,1)…(18,13); done once; cand_count=14; no gaps in win.
- Full line (row_occ=all 1s) → cand_valid never high; done in cycle k+15 after the start edge; cand_count=0.
- Only cell 3 empty → single candidate col=3, win=0; windows 1..3 suppressed as duplicates; cand_count=1.
- Empty line with cand_ready low 5 cycles on first candidate → cand_col=5, cand_win=0 stable throughout; no second candidate until acceptance; count 14 at end.
- abort asserted while the third candidate waits in EMIT → IDLE next cycle, cand_valid=0, no done, cand_count=2. A following start rescans from off=0 with count reset to 0.
- rst_n low for one cycle during SCAN, plus start pulsed while busy → all outputs return to reset values next cycle; the mid-scan start has no effect.
